ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 14 +
 rtl/btn_sync.sv | 25 ++
 rtl/ram_loader.sv | 97 +++++++++
 tb/tb_ram_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and default widths for the RAM loader.
package ram_loader_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAddrWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StCheck
    } state_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an active-low button, plus a one-cycle pulse on a press (1->0).
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic fall_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/ram_loader.sv
// Pushbutton-driven RAM writer: write one word, read it back, flag a mismatch.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned ADDRESS_WIDTH = DefAddrWidth
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     wr_en,
    input  logic                     auto_inc,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0]    data_out
);

    localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;

    logic                     req;
    state_e                   state_q;
    logic                     busy_q, done_q, error_q;
    logic [ADDRESS_WIDTH-1:0] wr_address_q, ptr_q;
    logic [DATA_WIDTH-1:0]    data_q, data_out_q;
    logic [DATA_WIDTH-1:0]    mem_q [Depth];

    // The synchronizer runs regardless of ce; a pulse seen while ce=0 simply expires.
    btn_sync u_btn_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (wr_en),
        .fall_o  (req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            wr_address_q <= '0;
            ptr_q        <= '0;
            data_q       <= '0;
            data_out_q   <= '0;
        end else if (ce) begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        data_q       <= data_in;
                        wr_address_q <= auto_inc ? ptr_q : address_in;
                        busy_q       <= 1'b1;
                        state_q      <= StWrite;
                    end
                end
                StWrite: begin
                    state_q <= StRead;
                end
                StRead: begin
                    data_out_q <= mem_q[wr_address_q];
                    state_q    <= StCheck;
                end
                StCheck: begin
                    error_q <= (data_out_q != data_q);
                    done_q  <= 1'b1;
                    if (auto_inc) begin
                        ptr_q <= ptr_q + ADDRESS_WIDTH'(1);
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // No reset on the array: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ce && state_q == StWrite) begin
            mem_q[wr_address_q] <= data_q;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign wr_address = wr_address_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader.
module tb_ram_loader;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n, ce, wr_en, auto_inc;
    logic [AW-1:0] address_in;
    logic [DW-1:0] data_in;
    logic          busy, done, error;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] data_out;

    int checks = 0;
    int errors = 0;
    int dones;

    always #5 clk = ~clk;

    ram_loader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .wr_en      (wr_en),
        .auto_inc   (auto_inc),
        .address_in (address_in),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .wr_address (wr_address),
        .data_out   (data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        check({tag, " busy rise"}, 32'(busy), 32'd1);
    endtask

    // Press, then verify exact T+4 latency and the written/read-back values.
    task automatic press(input string tag, input logic [AW-1:0] exp_addr,
                         input logic [DW-1:0] exp_data);
        wr_en = 1'b0;
        wait_busy(tag);
        step();
        step();
        check({tag, " busy T+3"}, 32'(busy), 32'd1);
        check({tag, " done T+3"}, 32'(done), 32'd0);
        step();
        check({tag, " done T+4"}, 32'(done), 32'd1);
        check({tag, " busy T+4"}, 32'(busy), 32'd0);
        check({tag, " wr_address"}, 32'(wr_address), 32'(exp_addr));
        check({tag, " data_out"}, 32'(data_out), 32'(exp_data));
        check({tag, " error"}, 32'(error), 32'd0);
        step();
        check({tag, " done width"}, 32'(done), 32'd0);
        wr_en = 1'b1;
        repeat (3) step();
    endtask

    task automatic press_quiet(input string tag);
        wr_en = 1'b0;
        wait_busy(tag);
        wr_en = 1'b1;
        repeat (3) step();
        check({tag, " done"}, 32'(done), 32'd1);
        repeat (3) step();
    endtask

    initial begin
        rst_n      = 1'b0;
        ce         = 1'b1;
        wr_en      = 1'b1;
        auto_inc   = 1'b0;
        address_in = '0;
        data_in    = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset wr_address", 32'(wr_address), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // Manual address write
        address_in = 8'h12;
        data_in    = 16'hBEEF;
        press("manual", 8'h12, 16'hBEEF);

        // Auto-increment from pointer 0
        auto_inc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            data_in = 16'(i);
            press("auto", 8'(i - 1), 16'(i));
        end
        data_in = 16'h0004;
        press("pointer at 3", 8'h03, 16'h0004);

        // Second falling edge arrives while busy and must be dropped
        data_in = 16'h0A0A;
        dones   = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) wr_en = 1'b0;
            if (c == 1) wr_en = 1'b1;
            if (c == 2) wr_en = 1'b0;
            if (c == 10) wr_en = 1'b1;
            step();
            if (done === 1'b1) dones++;
        end
        check("busy press done count", 32'(dones), 32'd1);
        check("busy press wr_address", 32'(wr_address), 32'h04);
        check("busy press data_out", 32'(data_out), 32'h0A0A);
        check("busy press idle", 32'(busy), 32'd0);
        data_in = 16'h0B0B;
        press("single write", 8'h05, 16'h0B0B);

        // ce low for 5 cycles while in READ
        auto_inc   = 1'b0;
        address_in = 8'h80;
        data_in    = 16'hC0DE;
        wr_en      = 1'b0;
        wait_busy("ce freeze");
        wr_en = 1'b1;
        step();
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("ce freeze done", 32'(done), 32'd0);
            check("ce freeze busy", 32'(busy), 32'd1);
        end
        check("ce freeze data_out held", 32'(data_out), 32'h0B0B);
        check("ce freeze wr_address held", 32'(wr_address), 32'h80);
        ce = 1'b1;
        step();
        check("ce resume done early", 32'(done), 32'd0);
        step();
        check("ce resume done", 32'(done), 32'd1);
        check("ce resume wr_address", 32'(wr_address), 32'h80);
        check("ce resume data_out", 32'(data_out), 32'hC0DE);
        check("ce resume error", 32'(error), 32'd0);
        repeat (3) step();

        // Press while ce=0 in IDLE is dropped
        ce    = 1'b0;
        wr_en = 1'b0;
        repeat (6) step();
        check("ce low press busy", 32'(busy), 32'd0);
        wr_en = 1'b1;
        repeat (3) step();
        ce = 1'b1;
        repeat (6) step();
        check("ce low press dropped", 32'(busy), 32'd0);

        // Reset in WRITE aborts the operation
        address_in = 8'h40;
        data_in    = 16'h1234;
        wr_en      = 1'b0;
        wait_busy("reset abort");
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort error", 32'(error), 32'd0);
        check("abort wr_address", 32'(wr_address), 32'd0);
        check("abort data_out", 32'(data_out), 32'd0);
        wr_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            step();
            if (done === 1'b1) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        address_in = 8'h41;
        data_in    = 16'h5678;
        press("after abort", 8'h41, 16'h5678);

        // Pointer wrap: 255 writes from 0, then 0xFF, then 0x00
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        auto_inc = 1'b1;
        for (int i = 0; i < 255; i++) begin
            data_in = 16'(i);
            press_quiet("fill");
        end
        data_in = 16'hAAAA;
        press("pointer 0xFF", 8'hFF, 16'hAAAA);
        data_in = 16'h5555;
        press("pointer wrap", 8'h00, 16'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
